// File: rtl/stage1_controller.sv
// -----------------------------------------------------------------------------
// stage1_controller
//
// Sequencer and two-way round-robin arbiter for the stage-1 operand-read path.
// Port 0 (instruction sequencer) and port 1 (debug/monitor) share the stage-1
// source mux. One request is accepted at a time. Its select and source byte are
// registered onto the mux. The block then either handshakes a variable-latency
// RAM/device read, captures the constant path directly, or flags a reserved
// select. The captured 32-bit value and an error flag are returned to the owner.
//
// Parameters:
//   TIMEOUT_CYCLES : max WAIT cycles before a read is aborted (1..255)
//
// Ports:
//   clk, reset_n                 : clock (rising edge), async active-low reset
//   req{0,1}_valid/_sel/_source  : request, source select, address/constant
//   req{0,1}_ready               : request accepted this cycle (IDLE only)
//   rsp{0,1}_valid               : one-cycle response strobe to the owner
//   rsp_data, rsp_error          : shared response value and error flag
//   mblock_s1, vr_source         : registered select/source to the stage-1 mux
//   vr_value                     : stage-1 mux output
//   ram_rd_en/ram_rd_ack         : RAM read request (held until ack) and ack
//   dev_rd_en/dev_rd_ack         : input-device read request and ack
// -----------------------------------------------------------------------------
module stage1_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [1:0]  req0_sel,
    input  logic [1:0]  req1_sel,
    input  logic [7:0]  req0_source,
    input  logic [7:0]  req1_source,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_error,
    output logic [1:0]  mblock_s1,
    output logic [7:0]  vr_source,
    input  logic [31:0] vr_value,
    output logic        ram_rd_en,
    input  logic        ram_rd_ack,
    output logic        dev_rd_en,
    input  logic        dev_rd_ack
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CAPTURE,
        ST_RESP
    } state_t;

    localparam logic [1:0] SEL_RAM   = 2'd0;
    localparam logic [1:0] SEL_DEV   = 2'd2;
    localparam logic [1:0] SEL_CONST = 2'd3;

    // Counter value in the last allowed WAIT cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    // Registered state
    state_t      r_state;
    logic        r_last_grant;
    logic        r_owner;
    logic [1:0]  r_mblock_s1;
    logic [7:0]  r_vr_source;
    logic [31:0] r_rsp_data;
    logic        r_rsp_error;
    logic        r_ram_rd_en;
    logic        r_dev_rd_en;
    logic [7:0]  r_wait_cnt;

    // Next-state values
    state_t      n_state;
    logic        n_last_grant;
    logic        n_owner;
    logic [1:0]  n_mblock_s1;
    logic [7:0]  n_vr_source;
    logic [31:0] n_rsp_data;
    logic        n_rsp_error;
    logic        n_ram_rd_en;
    logic        n_dev_rd_en;
    logic [7:0]  n_wait_cnt;

    // Arbitration / handshake wires
    logic        w_gnt;
    logic        w_ready0;
    logic        w_ready1;
    logic        w_accept;
    logic [1:0]  w_sel;
    logic [7:0]  w_src;
    logic        w_ack;

    // With both ports requesting, the port opposite the last owner wins;
    // otherwise the lone requester is granted.
    assign w_gnt    = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    assign w_ready0 = (r_state == ST_IDLE) && req0_valid && !w_gnt;
    assign w_ready1 = (r_state == ST_IDLE) && req1_valid &&  w_gnt;
    assign w_accept = w_ready0 || w_ready1;
    assign w_sel    = w_gnt ? req1_sel    : req0_sel;
    assign w_src    = w_gnt ? req1_source : req0_source;

    // Only the ack for the read actually in flight counts; the rd_en flags
    // are low outside WAIT, so stray acks elsewhere are filtered too.
    assign w_ack = (r_ram_rd_en && ram_rd_ack) || (r_dev_rd_en && dev_rd_ack);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_mblock_s1  <= 2'b11;
            r_vr_source  <= '0;
            r_rsp_data   <= '0;
            r_rsp_error  <= 1'b0;
            r_ram_rd_en  <= 1'b0;
            r_dev_rd_en  <= 1'b0;
            r_wait_cnt   <= '0;
        end else begin
            r_state      <= n_state;
            r_last_grant <= n_last_grant;
            r_owner      <= n_owner;
            r_mblock_s1  <= n_mblock_s1;
            r_vr_source  <= n_vr_source;
            r_rsp_data   <= n_rsp_data;
            r_rsp_error  <= n_rsp_error;
            r_ram_rd_en  <= n_ram_rd_en;
            r_dev_rd_en  <= n_dev_rd_en;
            r_wait_cnt   <= n_wait_cnt;
        end
    end

    always_comb begin
        n_state      = r_state;
        n_last_grant = r_last_grant;
        n_owner      = r_owner;
        n_mblock_s1  = r_mblock_s1;
        n_vr_source  = r_vr_source;
        n_rsp_data   = r_rsp_data;
        n_rsp_error  = r_rsp_error;
        n_ram_rd_en  = r_ram_rd_en;
        n_dev_rd_en  = r_dev_rd_en;
        n_wait_cnt   = r_wait_cnt;

        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    n_owner     = w_gnt;
                    n_mblock_s1 = w_sel;
                    n_vr_source = w_src;
                    n_wait_cnt  = '0;
                    case (w_sel)
                        SEL_RAM: begin
                            n_state     = ST_WAIT;
                            n_ram_rd_en = 1'b1;
                        end
                        SEL_DEV: begin
                            n_state     = ST_WAIT;
                            n_dev_rd_en = 1'b1;
                        end
                        SEL_CONST: begin
                            n_state = ST_CAPTURE;
                        end
                        default: begin
                            // Reserved select: answer with an error, no read.
                            n_state     = ST_RESP;
                            n_rsp_data  = '0;
                            n_rsp_error = 1'b1;
                        end
                    endcase
                end
            end

            ST_WAIT: begin
                // Ack is checked first so it wins in the final allowed cycle.
                if (w_ack) begin
                    n_rsp_data  = vr_value;
                    n_rsp_error = 1'b0;
                    n_ram_rd_en = 1'b0;
                    n_dev_rd_en = 1'b0;
                    n_state     = ST_RESP;
                end else if (r_wait_cnt == CNT_LAST) begin
                    n_rsp_data  = '0;
                    n_rsp_error = 1'b1;
                    n_ram_rd_en = 1'b0;
                    n_dev_rd_en = 1'b0;
                    n_state     = ST_RESP;
                end else begin
                    n_wait_cnt = r_wait_cnt + 8'd1;
                end
            end

            ST_CAPTURE: begin
                n_rsp_data  = vr_value;
                n_rsp_error = 1'b0;
                n_state     = ST_RESP;
            end

            ST_RESP: begin
                n_last_grant = r_owner;
                n_state      = ST_IDLE;
            end

            default: begin
                n_state = ST_IDLE;
            end
        endcase
    end

    assign req0_ready = w_ready0;
    assign req1_ready = w_ready1;
    assign rsp0_valid = (r_state == ST_RESP) && !r_owner;
    assign rsp1_valid = (r_state == ST_RESP) &&  r_owner;
    assign rsp_data   = r_rsp_data;
    assign rsp_error  = r_rsp_error;
    assign mblock_s1  = r_mblock_s1;
    assign vr_source  = r_vr_source;
    assign ram_rd_en  = r_ram_rd_en;
    assign dev_rd_en  = r_dev_rd_en;

endmodule

// File: tb/tb_stage1_controller.sv
// -----------------------------------------------------------------------------
// tb_stage1_controller
//
// Directed bench for stage1_controller with TIMEOUT_CYCLES = 4. Inputs are
// driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_stage1_controller;

    logic        clk;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_sel, req1_sel;
    logic [7:0]  req0_source, req1_source;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic [1:0]  mblock_s1;
    logic [7:0]  vr_source;
    logic [31:0] vr_value;
    logic        ram_rd_en, ram_rd_ack;
    logic        dev_rd_en, dev_rd_ack;

    // Stage-1 mux stand-in: either a driven value or the zero-extended
    // constant byte when the constant path is modelled.
    logic [31:0] vr_drv;
    logic        mux_model;
    assign vr_value = mux_model ? {24'h0, vr_source} : vr_drv;

    int total = 0;
    int bad   = 0;

    stage1_controller #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req0_valid  (req0_valid),
        .req1_valid  (req1_valid),
        .req0_ready  (req0_ready),
        .req1_ready  (req1_ready),
        .req0_sel    (req0_sel),
        .req1_sel    (req1_sel),
        .req0_source (req0_source),
        .req1_source (req1_source),
        .rsp0_valid  (rsp0_valid),
        .rsp1_valid  (rsp1_valid),
        .rsp_data    (rsp_data),
        .rsp_error   (rsp_error),
        .mblock_s1   (mblock_s1),
        .vr_source   (vr_source),
        .vr_value    (vr_value),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_ack  (ram_rd_ack),
        .dev_rd_en   (dev_rd_en),
        .dev_rd_ack  (dev_rd_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        total++; if (mblock_s1 !== 2'b11) begin bad++; $display("FAIL rst_mblock got=%0h want=3", mblock_s1); end
        total++; if (vr_source !== 8'h00) begin bad++; $display("FAIL rst_vr_source got=%0h want=0", vr_source); end
        total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL rst_rsp_data got=%0h want=0", rsp_data); end
        total++; if ({rsp_error, rsp0_valid, rsp1_valid, ram_rd_en, dev_rd_en, req0_ready, req1_ready} !== 7'b0)
            begin bad++; $display("FAIL rst_flags got=%b want=0000000", {rsp_error, rsp0_valid, rsp1_valid, ram_rd_en, dev_rd_en, req0_ready, req1_ready}); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_constant();
        vr_drv = 32'h0000_00A5;
        req0_valid = 1'b1; req0_sel = 2'd3; req0_source = 8'hA5;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL const_ready got=%b want=10", {req0_ready, req1_ready}); end
        tick(); // E0
        req0_valid = 1'b0;
        total++; if (mblock_s1 !== 2'd3 || vr_source !== 8'hA5) begin bad++; $display("FAIL const_mux got=%0h/%0h want=3/a5", mblock_s1, vr_source); end
        total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL const_early_rsp got=%b want=0", rsp0_valid); end
        tick(); // E1
        total++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin bad++; $display("FAIL const_rsp_valid got=%b%b want=10", rsp0_valid, rsp1_valid); end
        total++; if (rsp_data !== 32'h0000_00A5) begin bad++; $display("FAIL const_data got=%h want=000000a5", rsp_data); end
        total++; if (rsp_error !== 1'b0) begin bad++; $display("FAIL const_err got=%b want=0", rsp_error); end
        tick(); // E2
        total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL const_strobe_len got=%b want=0", rsp0_valid); end
        total++; if (rsp_data !== 32'h0000_00A5) begin bad++; $display("FAIL const_data_hold got=%h want=000000a5", rsp_data); end
    endtask

    task automatic test_ram_latency();
        req1_valid = 1'b1; req1_sel = 2'd0; req1_source = 8'h10;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL ram_ready got=%b want=01", {req0_ready, req1_ready}); end
        tick(); // E0
        req1_valid = 1'b0;
        total++; if (ram_rd_en !== 1'b1 || dev_rd_en !== 1'b0) begin bad++; $display("FAIL ram_en_c1 got=%b%b want=10", ram_rd_en, dev_rd_en); end
        total++; if (mblock_s1 !== 2'd0 || vr_source !== 8'h10) begin bad++; $display("FAIL ram_mux got=%0h/%0h want=0/10", mblock_s1, vr_source); end
        dev_rd_ack = 1'b1; // non-matching ack in WAIT cycle 1
        tick(); // E1
        dev_rd_ack = 1'b0;
        total++; if (ram_rd_en !== 1'b1 || rsp1_valid !== 1'b0) begin bad++; $display("FAIL ram_wrong_ack got=en%b rsp%b want=en1 rsp0", ram_rd_en, rsp1_valid); end
        tick(); // E2
        total++; if (ram_rd_en !== 1'b1) begin bad++; $display("FAIL ram_en_c3 got=%b want=1", ram_rd_en); end
        ram_rd_ack = 1'b1; vr_drv = 32'hDEAD_BEEF;
        tick(); // E3
        ram_rd_ack = 1'b0;
        total++; if (ram_rd_en !== 1'b0) begin bad++; $display("FAIL ram_en_drop got=%b want=0", ram_rd_en); end
        total++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0) begin bad++; $display("FAIL ram_rsp_valid got=%b%b want=01", rsp0_valid, rsp1_valid); end
        total++; if (rsp_data !== 32'hDEAD_BEEF || rsp_error !== 1'b0) begin bad++; $display("FAIL ram_data got=%h e%b want=deadbeef e0", rsp_data, rsp_error); end
        tick(); // E4
        total++; if (rsp1_valid !== 1'b0) begin bad++; $display("FAIL ram_strobe_len got=%b want=0", rsp1_valid); end
    endtask

    task automatic test_timeout();
        int n;
        req0_valid = 1'b1; req0_sel = 2'd2; req0_source = 8'h33;
        #1;
        tick(); // E0
        req0_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (dev_rd_en !== 1'b1) break;
            n++;
            tick();
        end
        total++; if (n !== 4) begin bad++; $display("FAIL to_en_cycles got=%0d want=4", n); end
        total++; if (rsp0_valid !== 1'b1) begin bad++; $display("FAIL to_rsp_valid got=%b want=1", rsp0_valid); end
        total++; if (rsp_error !== 1'b1 || rsp_data !== 32'h0) begin bad++; $display("FAIL to_err_data got=e%b %h want=e1 00000000", rsp_error, rsp_data); end
        dev_rd_ack = 1'b1; vr_drv = 32'h1234_5678; // late ack
        tick();
        total++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin bad++; $display("FAIL to_late_ack1 got=%b%b want=00", rsp0_valid, rsp1_valid); end
        tick();
        total++; if (rsp0_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_error !== 1'b1) begin bad++; $display("FAIL to_late_ack2 got=v%b %h e%b want=v0 00000000 e1", rsp0_valid, rsp_data, rsp_error); end
        dev_rd_ack = 1'b0;

        // Ack in the final allowed cycle wins over timeout.
        req0_valid = 1'b1; req0_sel = 2'd2; req0_source = 8'h44;
        #1;
        tick(); // E0
        req0_valid = 1'b0;
        tick(); tick(); tick(); // E1..E3
        total++; if (dev_rd_en !== 1'b1) begin bad++; $display("FAIL to_c4_en got=%b want=1", dev_rd_en); end
        dev_rd_ack = 1'b1; vr_drv = 32'hCAFE_F00D;
        tick(); // E4
        dev_rd_ack = 1'b0;
        total++; if (rsp0_valid !== 1'b1 || dev_rd_en !== 1'b0) begin bad++; $display("FAIL to_c4_rsp got=v%b en%b want=v1 en0", rsp0_valid, dev_rd_en); end
        total++; if (rsp_data !== 32'hCAFE_F00D || rsp_error !== 1'b0) begin bad++; $display("FAIL to_c4_data got=%h e%b want=cafef00d e0", rsp_data, rsp_error); end
        tick();
    endtask

    task automatic test_reserved();
        ram_rd_ack = 1'b1; // stray ack in IDLE
        tick();
        total++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin bad++; $display("FAIL stray_ack got=%b%b want=00", rsp0_valid, rsp1_valid); end
        tick();
        total++; if (rsp_data !== 32'hCAFE_F00D || rsp0_valid !== 1'b0) begin bad++; $display("FAIL stray_ack_hold got=%h v%b want=cafef00d v0", rsp_data, rsp0_valid); end
        ram_rd_ack = 1'b0;
        req1_valid = 1'b1; req1_sel = 2'd1; req1_source = 8'h77;
        #1;
        total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL rsvd_ready got=%b want=1", req1_ready); end
        tick(); // E0
        req1_valid = 1'b0;
        total++; if (ram_rd_en !== 1'b0 || dev_rd_en !== 1'b0) begin bad++; $display("FAIL rsvd_no_read got=%b%b want=00", ram_rd_en, dev_rd_en); end
        total++; if (rsp1_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_data !== 32'h0) begin bad++; $display("FAIL rsvd_rsp got=v%b e%b %h want=v1 e1 00000000", rsp1_valid, rsp_error, rsp_data); end
        total++; if (mblock_s1 !== 2'd1) begin bad++; $display("FAIL rsvd_mblock got=%0h want=1", mblock_s1); end
        tick(); // E1
        total++; if (rsp1_valid !== 1'b0) begin bad++; $display("FAIL rsvd_strobe_len got=%b want=0", rsp1_valid); end
    endtask

    task automatic test_arbitration();
        int wait_n;
        logic exp;
        mux_model = 1'b1;
        req0_valid = 1'b1; req0_sel = 2'd3; req0_source = 8'h11;
        req1_valid = 1'b1; req1_sel = 2'd3; req1_source = 8'h22;
        #1;
        for (int g = 0; g < 4; g++) begin
            exp = g[0];
            wait_n = 0;
            while (!(req0_ready || req1_ready) && wait_n < 4) begin
                tick();
                wait_n++;
            end
            total++; if (wait_n !== 0) begin bad++; $display("FAIL arb_idle_gap[%0d] got=%0d want=0", g, wait_n); end
            total++; if ({req1_ready, req0_ready} !== (exp ? 2'b10 : 2'b01)) begin bad++; $display("FAIL arb_grant[%0d] got=r1r0=%b want=port%0d", g, {req1_ready, req0_ready}, exp); end
            tick(); // accept
            total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++; $display("FAIL arb_ready_pulse[%0d] got=%b%b want=00", g, req0_ready, req1_ready); end
            tick(); // capture
            total++; if ({rsp1_valid, rsp0_valid} !== (exp ? 2'b10 : 2'b01)) begin bad++; $display("FAIL arb_rsp[%0d] got=r1r0=%b want=port%0d", g, {rsp1_valid, rsp0_valid}, exp); end
            total++; if (rsp_data !== (exp ? 32'h22 : 32'h11)) begin bad++; $display("FAIL arb_data[%0d] got=%h want=%h", g, rsp_data, (exp ? 32'h22 : 32'h11)); end
            tick(); // back to IDLE
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        mux_model = 1'b0;
        tick();
    endtask

    task automatic test_reset_midwait();
        req0_valid = 1'b1; req0_sel = 2'd0; req0_source = 8'h55;
        #1;
        tick(); // E0
        req0_valid = 1'b0;
        total++; if (ram_rd_en !== 1'b1) begin bad++; $display("FAIL mrst_pre_en got=%b want=1", ram_rd_en); end
        tick();
        reset_n = 1'b0;
        #1;
        total++; if (ram_rd_en !== 1'b0) begin bad++; $display("FAIL mrst_en_drop got=%b want=0", ram_rd_en); end
        total++; if (mblock_s1 !== 2'd3 || vr_source !== 8'h00) begin bad++; $display("FAIL mrst_mux got=%0h/%0h want=3/0", mblock_s1, vr_source); end
        ram_rd_ack = 1'b1; vr_drv = 32'hBAD0_BAD0;
        tick();
        ram_rd_ack = 1'b0;
        total++; if (rsp0_valid !== 1'b0 || rsp_data !== 32'h0) begin bad++; $display("FAIL mrst_no_rsp got=v%b %h want=v0 00000000", rsp0_valid, rsp_data); end
        reset_n = 1'b1;
        tick();
        total++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || ram_rd_en !== 1'b0) begin bad++; $display("FAIL mrst_after got=%b%b en%b want=00 en0", rsp0_valid, rsp1_valid, ram_rd_en); end
        req0_valid = 1'b1; req0_sel = 2'd3;
        req1_valid = 1'b1; req1_sel = 2'd3;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL mrst_idle_grant got=%b want=10", {req0_ready, req1_ready}); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_sel = '0; req1_sel = '0;
        req0_source = '0; req1_source = '0;
        ram_rd_ack = 1'b0; dev_rd_ack = 1'b0;
        vr_drv = '0; mux_model = 1'b0;

        test_reset();
        test_constant();
        test_ram_latency();
        test_timeout();
        test_reserved();
        test_arbitration();
        test_reset_midwait();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stage1_controller.md
# stage1_controller

Sequencer and two-way arbiter for the stage-1 operand-read path. Two requesters (instruction sequencer = port 0, debug/monitor = port 1) share the stage-1 source mux. The block grants one requester at a time round-robin and drives the mux select and source byte. It handshakes a variable-latency read with RAM or the input devices, or takes the constant path directly, then returns the captured 32-bit value with an error flag.

## Interface

Parameters:
- TIMEOUT_CYCLES, 15, maximum WAIT cycles before a read is aborted (1..255)

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request pending on port 0 / 1
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational, IDLE only)
- req0_sel / req1_sel  in  2  source select: 0 RAM, 1 reserved, 2 input device, 3 constant
- req0_source / req1_source  in  8  address or constant byte
- rsp0_valid / rsp1_valid  out  1  one-cycle response strobe to port 0 / 1
- rsp_data  out  32  response value, shared by both ports
- rsp_error  out  1  response is an error (reserved select or timeout)
- mblock_s1  out  2  registered select to the stage-1 mux
- vr_source  out  8  registered source byte to the stage-1 mux
- vr_value  in  32  stage-1 mux output
- ram_rd_en  out  1  RAM read request, held until ack
- ram_rd_ack  in  1  RAM data valid on vr_value this cycle
- dev_rd_en  out  1  input-device read request, held until ack
- dev_rd_ack  in  1  device data valid on vr_value this cycle

## Operation

- States: IDLE, WAIT, CAPTURE, RESP.
- Reset values: state IDLE, last_grant = 1 (port 0 wins first), mblock_s1 = 2'b11, vr_source = 0, rsp_data = 0, rsp_error = 0, all valid/ready/rd_en = 0, wait counter = 0.
- IDLE, grant:
  - Only one valid: grant it.
  - Both valid: grant the port opposite last_grant.
  - readyN = 1 only for the granted port; no ready outside IDLE.
- Accept (valid && ready at the edge):
  - Latch sel into mblock_s1 and source into vr_source.
  - Clear the wait counter.
  - Record grant owner.
- Next state after accept:
  - sel 0: WAIT, ram_rd_en = 1.
  - sel 2: WAIT, dev_rd_en = 1.
  - sel 3: CAPTURE.
  - sel 1: RESP with rsp_data = 0, rsp_error = 1; no read is issued.
- WAIT:
  - rd_en stays high.
  - Edge with the matching ack: rsp_data <= vr_value, rsp_error <= 0, rd_en <= 0, go to RESP.
  - No ack: counter increments.
  - No ack and counter == TIMEOUT_CYCLES-1: rd_en <= 0, rsp_data <= 0, rsp_error <= 1, go to RESP.
- Ack precedence and filtering:
  - Ack in the final allowed cycle wins over timeout.
  - The non-matching ack is ignored.
  - Acks in any state other than WAIT are ignored.
- CAPTURE: at the next edge rsp_data <= vr_value (zero-extended source byte from the mux), rsp_error <= 0, go to RESP.
- RESP:
  - rspN_valid = 1 for exactly one cycle, for the owner only; no backpressure.
  - last_grant <= owner; return to IDLE.
- Output holds:
  - rsp_data and rsp_error hold until the next response.
  - mblock_s1 and vr_source hold until the next accept.
- Reset mid-operation: immediate abort to reset values. No response is issued; the pending request is lost and the requester must retry.
- Requester changing inputs while not accepted: no effect. Inputs are sampled only at the accept edge.

## Timing

- Accept at edge E0; mblock_s1 and vr_source are valid from E0 onward.
- Constant path: capture at E1, rsp valid during E1–E2. Latency: 2 edges from accept to strobe.
- RAM/device path: ack in the k-th WAIT cycle (k = 1 means the cycle right after E0). Capture at E(k), rsp valid during E(k)–E(k+1).
- Reserved select: rsp valid during E0–E1.
- Timeout: rd_en high for exactly TIMEOUT_CYCLES cycles. rsp valid during the following cycle.
- Next accept no earlier than the edge ending RESP+1 (IDLE cycle). Peak throughput: one constant read per 3 cycles.
- ready depends combinationally only on state, valid and last_grant, never on ack.

## Test plan

- Reset: assert reset_n = 0 mid-WAIT. Required: ram_rd_en drops immediately, no rsp strobe, mblock_s1 = 3, vr_source = 0, state IDLE after release.
- Constant: port 0 sel = 3, source = 0xA5, mux returns 0x000000A5. Required: rsp0_valid exactly 2 edges after accept, rsp_data = 0x000000A5, rsp_error = 0.
- RAM latency: port 1 sel = 0, source = 0x10, ack after 3 WAIT cycles with vr_value = 0xDEADBEEF. Required: ram_rd_en high 3 cycles, rsp1_valid next cycle, rsp_data = 0xDEADBEEF.
- Arbitration: both ports valid continuously with constant requests. Required: grants alternate 0, 1, 0, 1; each ready is a single-cycle pulse; no port is starved.
- Timeout: TIMEOUT_CYCLES = 4, device read with no ack. Required: dev_rd_en high 4 cycles, then rsp_error = 1, rsp_data = 0. A late dev_rd_ack afterwards is ignored. Repeat with ack in cycle 4: success.
- Reserved select: sel = 1. Required: no rd_en, rsp valid the cycle after accept, rsp_error = 1. A stray ram_rd_ack in IDLE produces no response.
